// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, port ownership
// and default geometry of the fetch/data/RAM buses.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DATA
  } arb_owner_t;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned RD_LAT_DEF = 2;

  function automatic arb_owner_t other_owner(input arb_owner_t o);
    return (o == OWN_IF) ? OWN_DATA : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and single-port RAM signals.
// slave is the arbiter's view; master is the core/RAM side driving requests and read data.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_wdata, mem_we,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_wdata, mem_we,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin pick. req[0] is fetch, req[1] is data;
// on a tie the port that did not own the previous transaction wins.
module rr_arbiter_2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  arb_owner_t last,
  output arb_owner_t winner,
  output logic       any
);

  always_comb begin
    any    = |req;
    winner = OWN_IF;
    unique case (req)
      2'b01:   winner = OWN_IF;
      2'b10:   winner = OWN_DATA;
      2'b11:   winner = other_owner(last);
      default: winner = OWN_IF;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store with
// round-robin arbitration, one access in flight and fixed read latency.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  // Counter only has to reach RD_LAT-2; keep at least one bit for small latencies.
  localparam int unsigned CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (RD_LAT >= 2) ? CNT_W'(RD_LAT - 2) : '0;

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  arb_owner_t        owner_q, owner_d;
  arb_owner_t        last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;

  arb_owner_t        winner;
  logic              any_req;

  rr_arbiter_2 u_rr (
    .req    ({bus.d_req, bus.if_req}),
    .last   (last_q),
    .winner (winner),
    .any    (any_req)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_IF;
      last_q  <= OWN_DATA;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          if (winner == OWN_IF) begin
            addr_d  = bus.if_addr;
            wdata_d = '0;
            we_d    = 1'b0;
          end else begin
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            we_d    = bus.d_we;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q || (RD_LAT == 1)) begin
          state_d = RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode from registered state, so an async reset clears them at once.
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.mem_addr  = bus.busy ? addr_q : '0;
    bus.mem_wdata = bus.busy ? wdata_q : '0;
    bus.mem_we    = (state_q == ISSUE) && we_q;

    bus.if_gnt    = (state_q == ISSUE) && (owner_q == OWN_IF);
    bus.d_gnt     = (state_q == ISSUE) && (owner_q == OWN_DATA);

    bus.if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
    bus.d_rvalid  = (state_q == RESP) && (owner_q == OWN_DATA);

    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    bus.d_rdata   = (bus.d_rvalid && !we_q) ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (RD_LAT 2, 1, 4) share one stimulus and each
// drives its own behavioural RAM; instance 0 (RD_LAT=2) carries most checks.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;

  int checks = 0;
  int errors = 0;

  logic [2:0]  if_gnt_v, d_gnt_v, if_rvalid_v, d_rvalid_v, busy_v, mem_we_v;
  logic [63:0] if_rdata_v  [3];
  logic [63:0] d_rdata_v   [3];
  logic [63:0] mem_addr_v  [3];
  logic [63:0] mem_wdata_v [3];

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_lat
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );

    assign bus.if_req  = if_req;
    assign bus.if_addr = if_addr;
    assign bus.d_req   = d_req;
    assign bus.d_we    = d_we;
    assign bus.d_addr  = d_addr;
    assign bus.d_wdata = d_wdata;

    assign if_gnt_v[g]    = bus.if_gnt;
    assign d_gnt_v[g]     = bus.d_gnt;
    assign if_rvalid_v[g] = bus.if_rvalid;
    assign d_rvalid_v[g]  = bus.d_rvalid;
    assign busy_v[g]      = bus.busy;
    assign mem_we_v[g]    = bus.mem_we;
    assign if_rdata_v[g]  = bus.if_rdata;
    assign d_rdata_v[g]   = bus.d_rdata;
    assign mem_addr_v[g]  = bus.mem_addr;
    assign mem_wdata_v[g] = bus.mem_wdata;

    // RAM: word array plus a LAT-deep read pipeline from the address bus.
    logic [63:0] mem  [256];
    logic [63:0] pipe [LAT];

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 64'h0;
      for (int i = 0; i < LAT; i++) pipe[i] = 64'h0;
      mem[8] = 64'h0000_0013;
    end

    always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr[10:3]] <= bus.mem_wdata;
      pipe[0] <= mem[bus.mem_addr[10:3]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign bus.mem_rdata = pipe[LAT-1];

    logic if_req_d, d_req_d;
    int   out_if, out_d;

    always @(posedge clk) begin
      if_req_d <= if_req;
      d_req_d  <= d_req;
    end

    always @(negedge clk or negedge reset) begin
      if (!reset) begin
        out_if = 0;
        out_d  = 0;
      end else begin
        checks++;
        if (bus.if_gnt && bus.d_gnt) begin
          errors++;
          $display("FAIL gnt_excl[%0d]: if_gnt=%b d_gnt=%b, required at most one", g, bus.if_gnt, bus.d_gnt);
        end
        checks++;
        if (bus.if_rvalid && bus.d_rvalid) begin
          errors++;
          $display("FAIL rvalid_excl[%0d]: if_rvalid=%b d_rvalid=%b, required at most one", g, bus.if_rvalid, bus.d_rvalid);
        end
        if (bus.if_gnt) begin
          checks++;
          if (!if_req_d || out_if != 0) begin
            errors++;
            $display("FAIL if_gnt_legal[%0d]: req_prev=%b outstanding=%0d, required req_prev=1 outstanding=0", g, if_req_d, out_if);
          end
          out_if++;
        end
        if (bus.d_gnt) begin
          checks++;
          if (!d_req_d || out_d != 0) begin
            errors++;
            $display("FAIL d_gnt_legal[%0d]: req_prev=%b outstanding=%0d, required req_prev=1 outstanding=0", g, d_req_d, out_d);
          end
          out_d++;
        end
        if (bus.if_rvalid) begin
          checks++;
          if (out_if != 1) begin
            errors++;
            $display("FAIL if_rvalid_per_gnt[%0d]: outstanding=%0d, required 1", g, out_if);
          end
          out_if--;
        end
        if (bus.d_rvalid) begin
          checks++;
          if (out_d != 1) begin
            errors++;
            $display("FAIL d_rvalid_per_gnt[%0d]: outstanding=%0d, required 1", g, out_d);
          end
          out_d--;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    if_req = 1'b1;
    d_req  = 1'b1;
    idle(3);
    checks++;
    if ({if_gnt_v, d_gnt_v, if_rvalid_v, d_rvalid_v, busy_v, mem_we_v} !== 18'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h, required 0", {if_gnt_v, d_gnt_v, if_rvalid_v, d_rvalid_v, busy_v, mem_we_v});
    end
    checks++;
    if ((mem_addr_v[0] | mem_wdata_v[0] | if_rdata_v[0] | d_rdata_v[0]) !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h d_rdata=%h, required 0", mem_addr_v[0], mem_wdata_v[0], if_rdata_v[0], d_rdata_v[0]);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    reset  = 1'b1;
    idle(2);
    checks++;
    if (busy_v !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_busy: got %b, required 000", busy_v);
    end
  endtask

  task automatic test_tie_after_reset;
    if_req = 1'b1; if_addr = 64'h40;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 64'h40;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (if_gnt_v[0] !== (k == 1 || k == 9)) begin
        errors++;
        $display("FAIL tie_if_gnt k=%0d: got %b, required %b", k, if_gnt_v[0], (k == 1 || k == 9));
      end
      checks++;
      if (d_gnt_v[0] !== (k == 5)) begin
        errors++;
        $display("FAIL tie_d_gnt k=%0d: got %b, required %b", k, d_gnt_v[0], (k == 5));
      end
      checks++;
      if (if_rvalid_v[0] !== (k == 3) || d_rvalid_v[0] !== (k == 7)) begin
        errors++;
        $display("FAIL tie_rvalid k=%0d: if=%b d=%b, required if=%b d=%b", k, if_rvalid_v[0], d_rvalid_v[0], (k == 3), (k == 7));
      end
      if (k == 3 || k == 7) begin
        checks++;
        if ((if_rdata_v[0] | d_rdata_v[0]) !== 64'h13) begin
          errors++;
          $display("FAIL tie_rdata k=%0d: if=%h d=%h, required owner 13", k, if_rdata_v[0], d_rdata_v[0]);
        end
      end
      if (k == 9) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
    end
    idle(8);
  endtask

  task automatic test_single_fetch;
    if_req = 1'b1; if_addr = 64'h40;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) if_req = 1'b0;
      checks++;
      if (if_gnt_v[0] !== (k == 1) || if_rvalid_v[0] !== (k == 3)) begin
        errors++;
        $display("FAIL fetch_hs k=%0d: gnt=%b rvalid=%b, required gnt=%b rvalid=%b", k, if_gnt_v[0], if_rvalid_v[0], (k == 1), (k == 3));
      end
      checks++;
      if (mem_addr_v[0] !== ((k <= 3) ? 64'h40 : 64'h0) || busy_v[0] !== (k <= 3)) begin
        errors++;
        $display("FAIL fetch_addr_busy k=%0d: addr=%h busy=%b, required addr=%h busy=%b", k, mem_addr_v[0], busy_v[0], ((k <= 3) ? 64'h40 : 64'h0), (k <= 3));
      end
      checks++;
      if (if_rdata_v[0] !== ((k == 3) ? 64'h13 : 64'h0)) begin
        errors++;
        $display("FAIL fetch_rdata k=%0d: got %h, required %h", k, if_rdata_v[0], ((k == 3) ? 64'h13 : 64'h0));
      end
    end
    idle(6);
  endtask

  task automatic test_write_read;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'hDEAD_BEEF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        d_req = 1'b0;
        checks++;
        if (mem_addr_v[0] !== 64'h100 || mem_wdata_v[0] !== 64'hDEAD_BEEF) begin
          errors++;
          $display("FAIL wr_bus: addr=%h wdata=%h, required 100 deadbeef", mem_addr_v[0], mem_wdata_v[0]);
        end
      end
      checks++;
      if (mem_we_v[0] !== (k == 1) || d_gnt_v[0] !== (k == 1)) begin
        errors++;
        $display("FAIL wr_we_gnt k=%0d: we=%b gnt=%b, required %b", k, mem_we_v[0], d_gnt_v[0], (k == 1));
      end
      checks++;
      if (d_rvalid_v[0] !== (k == 2) || d_rdata_v[0] !== 64'h0 || busy_v[0] !== (k <= 2)) begin
        errors++;
        $display("FAIL wr_ack k=%0d: rvalid=%b rdata=%h busy=%b, required rvalid=%b rdata=0 busy=%b", k, d_rvalid_v[0], d_rdata_v[0], busy_v[0], (k == 2), (k <= 2));
      end
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) d_req = 1'b0;
      checks++;
      if (d_gnt_v[0] !== (k == 1) || d_rvalid_v[0] !== (k == 3) || mem_we_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL rd_hs k=%0d: gnt=%b rvalid=%b we=%b, required gnt=%b rvalid=%b we=0", k, d_gnt_v[0], d_rvalid_v[0], mem_we_v[0], (k == 1), (k == 3));
      end
      checks++;
      if (d_rdata_v[0] !== ((k == 3) ? 64'hDEAD_BEEF : 64'h0) || if_rdata_v[0] !== 64'h0) begin
        errors++;
        $display("FAIL rd_data k=%0d: d=%h if=%h, required d=%h if=0", k, d_rdata_v[0], if_rdata_v[0], ((k == 3) ? 64'hDEAD_BEEF : 64'h0));
      end
    end
    idle(6);
  endtask

  task automatic test_latency_sweep;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) d_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (d_gnt_v[i] !== (k == 1) || d_rvalid_v[i] !== (k == 1 + lat_of(i))) begin
          errors++;
          $display("FAIL lat_rd[lat=%0d] k=%0d: gnt=%b rvalid=%b, required gnt=%b rvalid=%b", lat_of(i), k, d_gnt_v[i], d_rvalid_v[i], (k == 1), (k == 1 + lat_of(i)));
        end
        checks++;
        if (d_rdata_v[i] !== ((k == 1 + lat_of(i)) ? 64'h13 : 64'h0)) begin
          errors++;
          $display("FAIL lat_rdata[lat=%0d] k=%0d: got %h, required %h", lat_of(i), k, d_rdata_v[i], ((k == 1 + lat_of(i)) ? 64'h13 : 64'h0));
        end
      end
    end
    idle(2);
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h80; d_wdata = 64'h55AA;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) d_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (d_rvalid_v[i] !== (k == 2) || mem_we_v[i] !== (k == 1) || d_rdata_v[i] !== 64'h0) begin
          errors++;
          $display("FAIL lat_wr[lat=%0d] k=%0d: rvalid=%b we=%b rdata=%h, required rvalid=%b we=%b rdata=0", lat_of(i), k, d_rvalid_v[i], mem_we_v[i], d_rdata_v[i], (k == 2), (k == 1));
        end
      end
    end
    idle(6);
  endtask

  task automatic test_reset_mid_wait;
    if_req = 1'b1; if_addr = 64'h40;
    @(negedge clk);
    if_req = 1'b0;
    idle(6);
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_busy: got %b, required 1", busy_v[0]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy_v !== 3'b000 || mem_addr_v[0] !== 64'h0 || d_gnt_v !== 3'b000 || d_rvalid_v !== 3'b000) begin
      errors++;
      $display("FAIL rst_async: busy=%b addr=%h gnt=%b rvalid=%b, required 0", busy_v, mem_addr_v[0], d_gnt_v, d_rvalid_v);
    end
    idle(2);
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (d_rvalid_v[0] !== 1'b0 || if_rvalid_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_resp k=%0d: d_rvalid=%b if_rvalid=%b busy=%b, required 0", k, d_rvalid_v[0], if_rvalid_v[0], busy_v[0]);
      end
    end
    if_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    checks++;
    if (if_gnt_v[0] !== 1'b1 || d_gnt_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_tie: if_gnt=%b d_gnt=%b, required 1 0", if_gnt_v[0], d_gnt_v[0]);
    end
    idle(6);
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h80; d_wdata = 64'h1;
    @(negedge clk);
    d_req = 1'b0;
    checks++;
    if (mem_we_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_wr_pre_we: got %b, required 1", mem_we_v[0]);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (mem_we_v !== 3'b000 || busy_v !== 3'b000) begin
      errors++;
      $display("FAIL rst_wr_async_we: we=%b busy=%b, required 000 000", mem_we_v, busy_v);
    end
    idle(2);
    reset = 1'b1;
    idle(4);
    checks++;
    if (busy_v[0] !== 1'b0 || d_rvalid_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_after: busy=%b rvalid=%b, required 0 0", busy_v[0], d_rvalid_v[0]);
    end
  endtask

  initial begin
    reset   = 1'b0;
    if_req  = 1'b0;
    if_addr = 64'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 64'h0;
    d_wdata = 64'h0;
    test_reset();
    test_tie_after_reset();
    test_single_fetch();
    test_write_read();
    test_latency_sweep();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
